// File: rtl/sound_in_if.sv
// rtl/sound_in_if.sv - CPU register bus for the delta-sigma sound input block
interface sound_in_if;
  logic [7:0] data_in;
  logic       wr;
  logic       rd;
  logic       sel;
  logic [7:0] data_out;

  modport master (
    output data_in,
    output wr,
    output rd,
    output sel,
    input  data_out
  );

  modport slave (
    input  data_in,
    input  wr,
    input  rd,
    input  sel,
    output data_out
  );
endinterface

// File: rtl/sound_in.sv
// rtl/sound_in.sv - 1-bit RC delta-sigma input: feedback drive, 255-cycle ones count, CPU sample/status
module sound_in #(
  parameter bit FB_INVERT = 1'b0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      snd_in,
  output logic      fb,
  sound_in_if.slave bus
);

  localparam logic [7:0] LAST_PHASE = 8'd254;

  logic       snd_meta;
  logic       s;
  logic       en;
  logic [7:0] phase;
  logic [7:0] ones;
  logic [7:0] sample;
  logic       valid;
  logic       overrun;
  logic       terminal;
  logic       consume;
  logic       unused_data_bits;

  assign terminal = en && (phase == LAST_PHASE);
  assign consume  = bus.rd && !bus.sel;

  assign unused_data_bits = ^bus.data_in[7:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      snd_meta <= 1'b0;
      s        <= 1'b0;
      en       <= 1'b0;
      fb       <= 1'b0;
      phase    <= 8'd0;
      ones     <= 8'd0;
      sample   <= 8'd0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      snd_meta <= snd_in;
      s        <= snd_meta;

      // en is sampled before the write lands, so a write on the terminal cycle still captures
      if (bus.wr) begin
        en <= bus.data_in[0];
      end

      fb <= en ? (s ^ FB_INVERT) : 1'b0;

      // Counters idle at zero while disabled, so every enable starts a fresh window
      if (!en || terminal) begin
        phase <= 8'd0;
        ones  <= 8'd0;
      end else begin
        phase <= phase + 8'd1;
        ones  <= ones + {7'd0, s};
      end

      if (consume) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end

      // The terminal update wins over a coinciding read; the read still sees the old sample
      if (terminal) begin
        sample  <= ones + {7'd0, s};
        valid   <= 1'b1;
        overrun <= valid && !consume;
      end
    end
  end

  assign bus.data_out = bus.sel ? {6'd0, overrun, valid} : sample;

endmodule

// File: tb/tb_sound_in.sv
// tb/tb_sound_in.sv - directed, table-driven self-checking bench for sound_in
module tb_sound_in;

  logic clk = 1'b0;
  logic reset;
  logic snd_in;
  logic fb;
  bit   toggle = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   n;

  sound_in_if bus ();

  always #5 clk = ~clk;

  sound_in #(.FB_INVERT(1'b0)) dut (
    .clk    (clk),
    .reset  (reset),
    .snd_in (snd_in),
    .fb     (fb),
    .bus    (bus)
  );

  typedef struct {
    logic [1:0] mode;    // 0: constant 0, 1: constant 1, 2: toggle every cycle
    logic [7:0] lo;
    logic [7:0] hi;
    bit         chk_fb;
    logic       exp_fb;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle) snd_in = ~snd_in;
  endtask

  task automatic set_sel(input logic v);
    bus.sel = v;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_en(input logic [7:0] v);
    bus.data_in = v;
    bus.wr = 1'b1;
    tick();
    bus.wr = 1'b0;
  endtask

  task automatic consume();
    bus.rd = 1'b1;
    bus.sel = 1'b0;
    tick();
    bus.rd = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int cnt);
    set_sel(1'b1);
    cnt = 0;
    while (bus.data_out[0] !== 1'b1 && cnt < max) begin
      tick();
      cnt++;
    end
    check("valid_seen", int'(bus.data_out[0] === 1'b1), 1);
  endtask

  initial begin
    reset = 1'b1;
    snd_in = 1'b0;
    bus.data_in = 8'd0;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.sel = 1'b0;

    vecs[0] = '{mode: 2'd0, lo: 8'd0,   hi: 8'd0,   chk_fb: 1'b1, exp_fb: 1'b0};
    vecs[1] = '{mode: 2'd1, lo: 8'hFF,  hi: 8'hFF,  chk_fb: 1'b1, exp_fb: 1'b1};
    vecs[2] = '{mode: 2'd2, lo: 8'd127, hi: 8'd128, chk_fb: 1'b0, exp_fb: 1'b0};

    // Reset state
    do_reset();
    set_sel(1'b1);
    check("reset_status", bus.data_out, 8'h00);
    check("reset_fb", fb, 0);
    set_sel(1'b0);
    check("reset_sample", bus.data_out, 8'h00);

    // Constant and toggling inputs, two windows each
    for (int i = 0; i < 3; i++) begin
      do_reset();
      snd_in = (vecs[i].mode == 2'd1);
      toggle = (vecs[i].mode == 2'd2);
      repeat (3) tick();
      write_en(8'h01);
      wait_valid(300, n);
      check($sformatf("vec%0d_latency", i), n, 255);
      if (vecs[i].chk_fb) check($sformatf("vec%0d_fb", i), fb, vecs[i].exp_fb);
      set_sel(1'b0);
      check($sformatf("vec%0d_sample1", i),
            int'(bus.data_out >= vecs[i].lo && bus.data_out <= vecs[i].hi), 1);
      consume();
      set_sel(1'b1);
      check($sformatf("vec%0d_cleared", i), bus.data_out, 8'h00);
      wait_valid(300, n);
      set_sel(1'b0);
      check($sformatf("vec%0d_sample2", i),
            int'(bus.data_out >= vecs[i].lo && bus.data_out <= vecs[i].hi), 1);
      toggle = 1'b0;
      write_en(8'h00);
    end

    // Overrun after two unread windows; second window sees only two ones through the synchroniser
    do_reset();
    snd_in = 1'b1;
    repeat (3) tick();
    write_en(8'h01);
    wait_valid(300, n);
    snd_in = 1'b0;
    repeat (255) tick();
    set_sel(1'b1);
    check("overrun_status", bus.data_out, 8'h03);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    check("status_read_no_side_effect", bus.data_out, 8'h03);
    set_sel(1'b0);
    check("overrun_sample_second", bus.data_out, 8'h02);
    consume();
    set_sel(1'b1);
    check("overrun_cleared", bus.data_out, 8'h00);

    // Consuming read coinciding with the terminal cycle
    do_reset();
    snd_in = 1'b1;
    repeat (3) tick();
    write_en(8'h01);
    wait_valid(300, n);
    snd_in = 1'b0;
    repeat (254) tick();
    bus.rd = 1'b1;
    set_sel(1'b0);
    check("terminal_read_old", bus.data_out, 8'hFF);
    tick();
    bus.rd = 1'b0;
    set_sel(1'b1);
    check("terminal_read_status", bus.data_out, 8'h01);
    set_sel(1'b0);
    check("terminal_read_new", bus.data_out, 8'h02);

    // Reset at phase 100 abandons the window; re-enable takes a full window
    do_reset();
    snd_in = 1'b1;
    repeat (3) tick();
    write_en(8'h01);
    repeat (100) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_sel(1'b1);
    check("midreset_status", bus.data_out, 8'h00);
    repeat (260) tick();
    check("midreset_no_sample", bus.data_out, 8'h00);
    write_en(8'h01);
    wait_valid(300, n);
    check("midreset_latency", n, 255);
    set_sel(1'b0);
    check("midreset_sample", bus.data_out, 8'hFF);

    // Reset overrides a simultaneous enable write
    reset = 1'b1;
    bus.data_in = 8'h01;
    bus.wr = 1'b1;
    tick();
    reset = 1'b0;
    bus.wr = 1'b0;
    repeat (4) tick();
    check("reset_over_wr_fb", fb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
